// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider. New ratios arrive over a valid/ready
// handshake and take effect only on period boundaries, so every period is whole.
module clk_div_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEFAULT_N = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_n,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] cur_n
);

    typedef enum logic [1:0] {IDLE, RUN, PEND, DRAIN} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cur_n;
    logic [WIDTH-1:0] r_pend_n;
    logic             r_pend_vld;
    logic             r_div_clk;
    logic             r_tick;
    logic             r_cfg_err;
    logic             r_busy;
    logic             r_cfg_ready;

    logic             w_xfer;
    logic             w_bad;
    logic             w_good;
    logic             w_last;
    logic             w_stop;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_cur_n_next;
    logic [WIDTH-1:0] w_pend_n_next;
    logic             w_pend_vld_next;
    logic [WIDTH:0]   w_half;
    logic             w_div_next;
    logic             w_tick_next;

    assign w_xfer = cfg_valid && r_cfg_ready;
    assign w_bad  = w_xfer && (cfg_n < TWO);
    assign w_good = w_xfer && !w_bad;
    assign w_last = (r_state != IDLE) && (r_cnt == r_cur_n - ONE);
    assign w_stop = w_last && !en;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // DRAIN counts exactly like RUN/PEND; en alone decides whether the
    // boundary ends the run, so re-raising en mid-drain leaves no gap.
    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE) begin
            if (en) w_state_next = r_pend_vld ? PEND : RUN;
        end else if (w_stop) begin
            w_state_next = IDLE;
        end else if (!en) begin
            w_state_next = DRAIN;
        end else begin
            w_state_next = w_pend_vld_next ? PEND : RUN;
        end
    end

    always_comb begin
        w_cur_n_next    = r_cur_n;
        w_pend_n_next   = r_pend_n;
        w_pend_vld_next = r_pend_vld;
        w_cnt_next      = '0;
        w_half          = '0;
        w_div_next      = 1'b0;
        w_tick_next     = 1'b0;
        if (r_state == IDLE) begin
            if (w_good) w_cur_n_next = cfg_n;
            w_div_next = en;
        end else begin
            if (w_last && r_pend_vld) begin
                w_cur_n_next    = r_pend_n;
                w_pend_vld_next = 1'b0;
            end
            // A ratio accepted on the stopping boundary has no later boundary
            // to wait for, so it is installed directly.
            if (w_good) begin
                if (w_stop) begin
                    w_cur_n_next = cfg_n;
                end else begin
                    w_pend_n_next   = cfg_n;
                    w_pend_vld_next = 1'b1;
                end
            end
            w_cnt_next  = w_last ? '0 : r_cnt + ONE;
            w_half      = ({1'b0, w_cur_n_next} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
            w_div_next  = !w_stop && ({1'b0, w_cnt_next} < w_half);
            w_tick_next = !w_stop && (w_cnt_next == w_cur_n_next - ONE);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= '0;
            r_cur_n     <= WIDTH'(DEFAULT_N);
            r_pend_n    <= '0;
            r_pend_vld  <= 1'b0;
            r_div_clk   <= 1'b0;
            r_tick      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_next;
            r_cur_n     <= w_cur_n_next;
            r_pend_n    <= w_pend_n_next;
            r_pend_vld  <= w_pend_vld_next;
            r_div_clk   <= w_div_next;
            r_tick      <= w_tick_next;
            r_cfg_err   <= w_bad;
            r_busy      <= (w_state_next != IDLE);
            r_cfg_ready <= (w_state_next == IDLE) || (w_state_next == RUN);
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign div_clk   = r_div_clk;
    assign tick      = r_tick;
    assign busy      = r_busy;
    assign cur_n     = r_cur_n;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl: a period-level reference model predicts
// every output each cycle; outputs are sampled on the falling edge.
module tb_clk_div_ctrl;

    localparam int W  = 32;
    localparam int DN = 1000;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_n = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         div_clk;
    logic         tick;
    logic         busy;
    logic [W-1:0] cur_n;

    clk_div_ctrl #(.WIDTH(W), .DEFAULT_N(DN)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy),
        .cur_n     (cur_n)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: running flag, position within the period, ratio, held configs.
    bit m_act, m_stop, m_div, m_tick, m_err, m_busy, m_ready, m_xfer;
    int m_pos, m_n;
    int pendq[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_act = 0; m_stop = 0; m_div = 0; m_tick = 0; m_err = 0;
        m_busy = 0; m_ready = 1; m_xfer = 0; m_pos = 0; m_n = DN;
        pendq.delete();
    endfunction

    function automatic void model_step(input bit e, input bit v, input int n);
        bit bnd;
        int held;
        bnd    = m_act && (m_pos == m_n - 1);
        held   = pendq.size();
        m_xfer = v && m_ready;
        m_err  = m_xfer && (n < 2);
        if (!m_act) begin
            if (m_xfer && n >= 2) m_n = n;
            m_pos  = 0;
            m_tick = 0;
            m_div  = e;
            m_act  = e;
        end else begin
            if (m_xfer && n >= 2) pendq.push_back(n);
            if (bnd) begin
                m_pos = 0;
                if (!e) begin
                    while (pendq.size() > 0) m_n = pendq.pop_front();
                    m_act = 0;
                end else if (held > 0) begin
                    m_n = pendq.pop_front();
                end
            end else begin
                m_pos++;
            end
            m_div  = m_act && (2 * m_pos < m_n);
            m_tick = m_act && (m_pos == m_n - 1);
        end
        m_stop  = m_act && !e;
        m_busy  = m_act;
        m_ready = !m_act || (!m_stop && pendq.size() == 0);
    endfunction

    task automatic check_all();
        check_val("div_clk",   32'(div_clk),   32'(m_div));
        check_val("tick",      32'(tick),      32'(m_tick));
        check_val("cfg_err",   32'(cfg_err),   32'(m_err));
        check_val("busy",      32'(busy),      32'(m_busy));
        check_val("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check_val("cur_n",     cur_n,          32'(m_n));
    endtask

    // Called at a falling edge; en toggles with odds 1/en_flip, new configs
    // start with odds 1/cfg_rate and are held until the model accepts them.
    task automatic run_cycles(input int cycles, input int en_flip, input int cfg_rate);
        for (int i = 0; i < cycles; i++) begin
            check_all();
            if (!(cfg_valid && !m_xfer)) begin
                cfg_valid = (cfg_rate > 0) && ($urandom_range(cfg_rate - 1) == 0);
                cfg_n     = W'($urandom_range(0, 12));
            end
            if (en_flip > 0 && $urandom_range(en_flip - 1) == 0) en = ~en;
            model_step(en, cfg_valid, int'(cfg_n));
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        #2 RST = 1'b1;
        cfg_valid = 1'b0;
        en = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        en  = 1'b1;
        run_cycles(2100, 0, 0);
        do_reset();
        run_cycles(4000, 25, 8);
        for (int k = 0; k < 4; k++) begin
            run_cycles($urandom_range(50, 300), 40, 4);
            do_reset();
        end
        run_cycles(6000, 60, 20);
        en = 1'b1;
        run_cycles(3000, 200, 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
